caravel_if_wb: RTL and testbench

Parametrised Caravel user-area interface for the multi-project mux. Maps pad fields to `sel`/`in`/`out` like the first-generation interface. Adds:
- a Wishbone register bank that can take over project select and inputs from the management SoC;
- 2-flop synchronisers on pad inputs;
- a stretched project reset, issued automatically on every select change or on software request.

Sits between the Caravel harness and the project muxes.

---
 rtl/caravel_if_pkg.sv | 34 +++
 rtl/caravel_if_sync2.sv | 29 ++
 rtl/caravel_if_wb.sv | 152 +++++++++++++++
 tb/tb_caravel_if_wb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/caravel_if_pkg.sv
// Shared definitions for the Caravel user-area interface: pad count, register
// word offsets, CTRL bit positions and the INFO word layout.
package caravel_if_pkg;

  localparam int MPRJ_IO_PADS = 38;

  // Register word offsets (wbs_adr_i[7:2])
  localparam logic [5:0] REG_CTRL = 6'h00;
  localparam logic [5:0] REG_SEL  = 6'h01;
  localparam logic [5:0] REG_IN   = 6'h02;
  localparam logic [5:0] REG_OUT  = 6'h03;
  localparam logic [5:0] REG_RST  = 6'h04;
  localparam logic [5:0] REG_INFO = 6'h05;

  localparam int CTRL_SRC = 0;
  localparam int CTRL_OE  = 1;

  localparam int INFO_SKIP_LSB = 0;
  localparam int INFO_SEL_LSB  = 8;
  localparam int INFO_IN_LSB   = 16;
  localparam int INFO_OUT_LSB  = 24;

  function automatic logic [31:0] info_word(input int skip_bits, input int sel_bits,
                                            input int input_bits, input int output_bits);
    logic [31:0] w;
    w = '0;
    w[INFO_SKIP_LSB +: 8] = 8'(skip_bits);
    w[INFO_SEL_LSB  +: 8] = 8'(sel_bits);
    w[INFO_IN_LSB   +: 8] = 8'(input_bits);
    w[INFO_OUT_LSB  +: 8] = 8'(output_bits);
    return w;
  endfunction

endpackage

// File: rtl/caravel_if_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs, both flops cleared by a
// synchronous active-high reset.
module caravel_if_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      // stage 0: capture pad, may go metastable
      meta_p0 <= d;
      // stage 1: settled copy
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/caravel_if_wb.sv
// Caravel user-area interface for the multi-project mux: pad field mapping,
// Wishbone register bank overriding select/inputs, and a stretched project reset.
module caravel_if_wb
  import caravel_if_pkg::*;
#(
  parameter int          SKIP_BITS   = 8,
  parameter int          SEL_BITS    = 6,
  parameter int          INPUT_BITS  = 10,
  parameter int          OUTPUT_BITS = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          RST_CYCLES  = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic [127:0]            la_data_in,
  output logic [127:0]            la_data_out,
  input  logic [127:0]            la_oenb,
  input  logic [MPRJ_IO_PADS-1:0] io_in,
  output logic [MPRJ_IO_PADS-1:0] io_out,
  output logic [MPRJ_IO_PADS-1:0] io_oeb,
  input  logic                    user_clock2,
  output logic [2:0]              user_irq,
  output logic                    clk,
  output logic                    rst_n,
  output logic [SEL_BITS-1:0]     sel,
  output logic [INPUT_BITS-1:0]   in,
  input  logic [OUTPUT_BITS-1:0]  out
);

  localparam int SEL_LSB = SKIP_BITS;
  localparam int IN_LSB  = SKIP_BITS + SEL_BITS;
  localparam int OUT_LSB = IN_LSB + INPUT_BITS;
  localparam int CW      = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES);
  localparam logic [31:0]   INFO     = info_word(SKIP_BITS, SEL_BITS, INPUT_BITS, OUTPUT_BITS);

  logic [SEL_BITS-1:0]   sync_sel, sel_reg, sel_nxt, prev_sel;
  logic [INPUT_BITS-1:0] sync_in, in_reg, in_nxt;
  logic                  ctrl_src, ctrl_oe;
  logic [CW-1:0]         rst_cnt;
  logic                  hit, req, wr, soft_rst, sel_change, busy;
  logic [31:0]           rd_data;
  logic                  unused_ok;

  assign clk         = wb_clk_i;
  assign la_data_out = '0;
  assign user_irq    = '0;
  assign unused_ok   = &{1'b0, la_data_in, la_oenb, user_clock2, io_in, wbs_adr_i, wbs_dat_i};

  caravel_if_sync2 #(
    .WIDTH(SEL_BITS + INPUT_BITS)
  ) u_sync (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .d  (io_in[SEL_LSB +: SEL_BITS + INPUT_BITS]),
    .q  ({sync_in, sync_sel})
  );

  assign sel = ctrl_src ? sel_reg : sync_sel;
  assign in  = ctrl_src ? in_reg  : sync_in;

  // Only the output field is ever driven; everything else stays an input.
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    io_out[OUT_LSB +: OUTPUT_BITS] = out;
    io_oeb[OUT_LSB +: OUTPUT_BITS] = {OUTPUT_BITS{~ctrl_oe}};
  end

  assign hit        = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req        = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & hit;
  assign wr         = req & wbs_we_i;
  assign soft_rst   = wr && (wbs_adr_i[7:2] == REG_RST);
  assign sel_change = (sel != prev_sel);
  assign busy       = (rst_cnt != '0);
  assign rst_n      = ~busy;

  always_comb begin
    sel_nxt = sel_reg;
    for (int i = 0; i < SEL_BITS; i++)
      if (wbs_sel_i[i / 8]) sel_nxt[i] = wbs_dat_i[i];
  end

  always_comb begin
    in_nxt = in_reg;
    for (int i = 0; i < INPUT_BITS; i++)
      if (wbs_sel_i[i / 8]) in_nxt[i] = wbs_dat_i[i];
  end

  always_comb begin
    rd_data = '0;
    case (wbs_adr_i[7:2])
      REG_CTRL: begin
        rd_data[CTRL_SRC] = ctrl_src;
        rd_data[CTRL_OE]  = ctrl_oe;
      end
      REG_SEL:  rd_data[SEL_BITS-1:0]    = sel_reg;
      REG_IN:   rd_data[INPUT_BITS-1:0]  = in_reg;
      REG_OUT:  rd_data[OUTPUT_BITS-1:0] = out;
      REG_RST:  rd_data[0]               = busy;
      REG_INFO: rd_data                  = INFO;
      default:  rd_data                  = '0;
    endcase
  end

  // Wishbone slave: one-cycle ack, registered read data, writes land on the ack edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ctrl_src  <= 1'b0;
      ctrl_oe   <= 1'b1;
      sel_reg   <= '0;
      in_reg    <= '0;
    end else begin
      wbs_ack_o <= req;
      if (req) wbs_dat_o <= rd_data;
      if (wr) begin
        case (wbs_adr_i[7:2])
          REG_CTRL: if (wbs_sel_i[0]) begin
            ctrl_src <= wbs_dat_i[CTRL_SRC];
            ctrl_oe  <= wbs_dat_i[CTRL_OE];
          end
          REG_SEL: sel_reg <= sel_nxt;
          REG_IN:  in_reg  <= in_nxt;
          default: ;
        endcase
      end
    end
  end

  // Any trigger reloads the full stretch rather than adding to what remains.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rst_cnt  <= RST_LOAD;
      prev_sel <= '0;
    end else begin
      prev_sel <= sel;
      if (soft_rst || sel_change) rst_cnt <= RST_LOAD;
      else if (busy)              rst_cnt <= rst_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_caravel_if_wb.sv
// Directed plus randomized bench for caravel_if_wb against a timestamp-based
// behavioural model of the register bank, pad path and reset stretcher.
module tb_caravel_if_wb;
  import caravel_if_pkg::*;

  localparam int RST_CYCLES = 8;

  logic        wb_clk_i, wb_rst_i, wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o;
  logic [127:0] la_data_in, la_data_out, la_oenb;
  logic [MPRJ_IO_PADS-1:0] io_in, io_out, io_oeb;
  logic        user_clock2, clk, rst_n;
  logic [2:0]  user_irq;
  logic [5:0]  sel_o;
  logic [9:0]  in_o;
  logic [13:0] out_v;

  int n_checks = 0;
  int n_pass   = 0;

  caravel_if_wb dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_data_in(la_data_in), .la_data_out(la_data_out), .la_oenb(la_oenb),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .user_clock2(user_clock2), .user_irq(user_irq),
    .clk(clk), .rst_n(rst_n), .sel(sel_o), .in(in_o), .out(out_v)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: rst_n is high once RST_CYCLES edges have passed since the
  // most recent trigger edge; pads reach sel/in two edges after being sampled.
  int          mcyc = 0;
  int          last_trig = 0;
  logic        m_src, m_oe, m_ack;
  logic [5:0]  m_selr, s1_sel, s2_sel, eff_prev;
  logic [9:0]  m_inr, s1_in, s2_in;
  logic [31:0] m_dat;

  function automatic logic [5:0] exp_sel();
    return m_src ? m_selr : s2_sel;
  endfunction

  function automatic logic [9:0] exp_in();
    return m_src ? m_inr : s2_in;
  endfunction

  function automatic logic exp_rstn();
    return (mcyc - last_trig) >= RST_CYCLES;
  endfunction

  always @(posedge wb_clk_i) begin
    logic [5:0]  eff_now;
    logic        was_busy;
    logic [31:0] rd;
    mcyc = mcyc + 1;
    if (wb_rst_i) begin
      m_src = 1'b0; m_oe = 1'b1; m_selr = '0; m_inr = '0;
      s1_sel = '0; s2_sel = '0; s1_in = '0; s2_in = '0;
      m_ack = 1'b0; m_dat = '0; eff_prev = '0; last_trig = mcyc;
    end else begin
      was_busy = (mcyc - 1 - last_trig) < RST_CYCLES;
      eff_now  = exp_sel();
      if (eff_now != eff_prev) last_trig = mcyc;
      eff_prev = eff_now;
      if (wbs_stb_i && wbs_cyc_i && !m_ack && wbs_adr_i[31:8] == 24'h300000) begin
        case (wbs_adr_i[7:2])
          6'd0:    rd = {30'b0, m_oe, m_src};
          6'd1:    rd = {26'b0, m_selr};
          6'd2:    rd = {22'b0, m_inr};
          6'd3:    rd = {18'b0, out_v};
          6'd4:    rd = {31'b0, was_busy};
          6'd5:    rd = {8'd14, 8'd10, 8'd6, 8'd8};
          default: rd = '0;
        endcase
        m_ack = 1'b1;
        m_dat = rd;
        if (wbs_we_i) begin
          case (wbs_adr_i[7:2])
            6'd0: if (wbs_sel_i[0]) {m_oe, m_src} = wbs_dat_i[1:0];
            6'd1: if (wbs_sel_i[0]) m_selr = wbs_dat_i[5:0];
            6'd2: begin
              if (wbs_sel_i[0]) m_inr[7:0] = wbs_dat_i[7:0];
              if (wbs_sel_i[1]) m_inr[9:8] = wbs_dat_i[9:8];
            end
            6'd4: last_trig = mcyc;
            default: ;
          endcase
        end
      end else begin
        m_ack = 1'b0;
      end
      s2_sel = s1_sel; s1_sel = io_in[13:8];
      s2_in  = s1_in;  s1_in  = io_in[23:14];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    logic [MPRJ_IO_PADS-1:0] e_out, e_oeb;
    @(posedge wb_clk_i);
    #1;
    e_out = '0;
    e_out[37:24] = out_v;
    e_oeb = '1;
    e_oeb[37:24] = {14{~m_oe}};
    check("sel", 64'(sel_o), 64'(exp_sel()));
    check("in", 64'(in_o), 64'(exp_in()));
    check("rst_n", 64'(rst_n), 64'(exp_rstn()));
    check("ack", 64'(wbs_ack_o), 64'(m_ack));
    if (m_ack) check("dat", 64'(wbs_dat_o), 64'(m_dat));
    check("io_out", 64'(io_out), 64'(e_out));
    check("io_oeb", 64'(io_oeb), 64'(e_oeb));
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] be, input logic expect_ack, output logic [31:0] rdata);
    logic got;
    got = 1'b0;
    rdata = '0;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = be;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (wbs_ack_o === 1'b1) begin
        got = 1'b1;
        rdata = wbs_dat_o;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    check("ack_seen", 64'(got), 64'(expect_ack));
  endtask

  initial begin
    logic [31:0] rd;
    int t0;
    logic miss;
    logic [31:0] adr;
    wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
    la_data_in = '0; la_oenb = '1; user_clock2 = 1'b0;
    io_in = '0; out_v = '0;

    repeat (3) begin
      tick();
      check("rst_rstn", 64'(rst_n), 64'(0));
      check("rst_sel", 64'(sel_o), 64'(0));
      check("rst_ack", 64'(wbs_ack_o), 64'(0));
    end
    check("rst_dat", 64'(wbs_dat_o), 64'(0));
    check("clk_pass", 64'(clk), 64'(1));
    check("tieoffs", 64'({user_irq, la_data_out[31:0]}), 64'(0));
    wb_rst_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("release_rstn", 64'(rst_n), 64'(i == 8));
    end
    wb_xfer(1'b0, 32'h3000_0014, 32'h0, 4'hF, 1'b1, rd);
    check("info", 64'(rd), 64'h0E0A_0608);

    io_in[13:8] = 6'd5;
    io_in[23:14] = 10'h3FF;
    tick();
    check("pad_sel_1cyc", 64'(sel_o), 64'(0));
    tick();
    check("pad_sel", 64'(sel_o), 64'(5));
    check("pad_in", 64'(in_o), 64'h3FF);
    check("pad_rstn_pre", 64'(rst_n), 64'(1));
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("pad_stretch", 64'(rst_n), 64'(i == 9));
    end

    wb_xfer(1'b1, 32'h3000_0000, 32'h3, 4'hF, 1'b1, rd);
    wb_xfer(1'b1, 32'h3000_0004, 32'h2A, 4'hF, 1'b1, rd);
    check("ovr_sel", 64'(sel_o), 64'h2A);
    wb_xfer(1'b1, 32'h3000_0008, 32'h155, 4'hF, 1'b1, rd);
    check("ovr_in", 64'(in_o), 64'h155);
    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b1, rd);
    check("sel_readback", 64'(rd), 64'h2A);
    wb_xfer(1'b1, 32'h3000_0004, 32'h15, 4'h0, 1'b1, rd);
    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b1, rd);
    check("sel_be0", 64'(rd), 64'h2A);

    for (int i = 0; i < 20 && rst_n !== 1'b1; i++) tick();
    check("idle_rstn", 64'(rst_n), 64'(1));
    wb_xfer(1'b1, 32'h3000_0010, 32'h1, 4'hF, 1'b1, rd);
    t0 = mcyc;
    repeat (3) tick();
    wb_xfer(1'b1, 32'h3000_0010, 32'h0, 4'hF, 1'b1, rd);
    wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b1, rd);
    check("rst_busy", 64'(rd), 64'(1));
    for (int i = 0; i < 20 && rst_n !== 1'b1; i++) tick();
    check("soft_len", 64'(mcyc - t0), 64'(12));
    wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b1, rd);
    check("rst_idle", 64'(rd), 64'(0));

    out_v = 14'h1ABC;
    wb_xfer(1'b0, 32'h3000_000C, 32'h0, 4'hF, 1'b1, rd);
    check("out_read", 64'(rd), 64'h1ABC);
    check("out_pads", 64'(io_out[37:24]), 64'h1ABC);
    check("out_oeb_en", 64'(io_oeb[37:24]), 64'h0);
    wb_xfer(1'b1, 32'h3000_0000, 32'h1, 4'hF, 1'b1, rd);
    check("out_oeb_dis", 64'(io_oeb[37:24]), 64'h3FFF);

    wb_xfer(1'b0, 32'h3000_003C, 32'h0, 4'hF, 1'b1, rd);
    check("unmapped", 64'(rd), 64'h0);
    wb_xfer(1'b0, 32'h3000_0114, 32'h0, 4'hF, 1'b0, rd);

    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h3000_0004; wbs_dat_i = 32'h11; wbs_sel_i = 4'hF;
    wb_rst_i = 1'b1;
    tick();
    check("rstwr_ack0", 64'(wbs_ack_o), 64'(0));
    tick();
    check("rstwr_ack1", 64'(wbs_ack_o), 64'(0));
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wb_rst_i = 1'b0;
    tick();
    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b1, rd);
    check("rstwr_sel", 64'(rd), 64'h0);

    for (int it = 0; it < 150; it++) begin
      io_in = MPRJ_IO_PADS'({$urandom(), $urandom()});
      out_v = 14'($urandom());
      case ($urandom_range(0, 19))
        0: begin
          wb_rst_i = 1'b1;
          tick();
          tick();
          wb_rst_i = 1'b0;
        end
        1, 2, 3, 4: tick();
        default: begin
          miss = ($urandom_range(0, 7) == 0);
          adr = 32'h3000_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
          if (miss) adr = adr | 32'h0000_0300;
          wb_xfer(1'($urandom_range(0, 1)), adr, $urandom(), 4'($urandom_range(0, 15)), !miss, rd);
        end
      endcase
    end
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
